// File: rtl/ex_mem_skid_stage_if.sv
// -----------------------------------------------------------------------------
// ex_mem_skid_stage_if
// Valid/ready handshake bundle carrying one EX->MEM pipeline entry.
// The same interface type serves as the EX-side input and the MEM-side output
// of ex_mem_skid_stage.
//   master : drives valid and the payload, receives ready
//   slave  : receives valid and the payload, drives ready
// Payload fields (pipeline names in brackets):
//   reg_write [RegWrite], result_src [ResultSrc], mem_write [MemWrite],
//   funct3 [funct3], alu_result [ALUResult], write_data [WriteData],
//   rd [Rd], pc_plus4 [PCPlus4]
// -----------------------------------------------------------------------------
interface ex_mem_skid_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5
);
  logic                  valid;
  logic                  ready;
  logic                  reg_write;
  logic [1:0]            result_src;
  logic                  mem_write;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] write_data;
  logic [RD_WIDTH-1:0]   rd;
  logic [DATA_WIDTH-1:0] pc_plus4;

  modport master (
    output valid, reg_write, result_src, mem_write, funct3,
           alu_result, write_data, rd, pc_plus4,
    input  ready
  );

  modport slave (
    input  valid, reg_write, result_src, mem_write, funct3,
           alu_result, write_data, rd, pc_plus4,
    output ready
  );
endinterface

// File: rtl/ex_mem_skid_stage.sv
// -----------------------------------------------------------------------------
// ex_mem_skid_stage
// Elastic EX->MEM pipeline register with a 2-entry skid buffer and flush.
// MEM-side backpressure stalls EX without any combinational path from the
// MEM ready to the EX ready: ready toward EX depends only on stored state.
// Ports:
//   clk          clock
//   rst          synchronous reset, active-high (wins over flush)
//   flush_i      drop every held entry and the same-cycle input
//   ex_i         EX-side handshake + payload (slave: stage drives ready)
//   mem_o        MEM-side handshake + head payload (master)
//   stall_cnt_o  saturating count of cycles where EX is valid but blocked
// -----------------------------------------------------------------------------
module ex_mem_skid_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  ex_mem_skid_stage_if.slave       ex_i,
  ex_mem_skid_stage_if.master      mem_o,
  output logic [CNT_WIDTH-1:0]     stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // main invalid
    ST_ONE   = 2'd1,  // main valid, skid empty
    ST_FULL  = 2'd2   // main and skid valid
  } state_e;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] write_data;
    logic [RD_WIDTH-1:0]   rd;
    logic [DATA_WIDTH-1:0] pc_plus4;
  } entry_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  entry_t               main_q, main_d;   // head entry, visible on mem_o
  entry_t               skid_q, skid_d;   // second entry caught while MEM stalls
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  entry_t in_s;
  logic   ready_e_s;
  logic   valid_m_s;
  logic   acc_s;
  logic   pop_s;

  // Both handshake qualifiers come straight from the state flops.
  assign ready_e_s = (state_q != ST_FULL);
  assign valid_m_s = (state_q != ST_EMPTY);
  assign acc_s     = ex_i.valid & ready_e_s;
  assign pop_s     = valid_m_s & mem_o.ready;

  assign in_s.reg_write  = ex_i.reg_write;
  assign in_s.result_src = ex_i.result_src;
  assign in_s.mem_write  = ex_i.mem_write;
  assign in_s.funct3     = ex_i.funct3;
  assign in_s.alu_result = ex_i.alu_result;
  assign in_s.write_data = ex_i.write_data;
  assign in_s.rd         = ex_i.rd;
  assign in_s.pc_plus4   = ex_i.pc_plus4;

  // Next-state and entry movement; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Clearing the write enables guarantees a flushed entry can never write,
      // the remaining fields are left as don't-care.
      state_d          = ST_EMPTY;
      main_d.reg_write = 1'b0;
      main_d.mem_write = 1'b0;
      skid_d.reg_write = 1'b0;
      skid_d.mem_write = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc_s) begin
            main_d  = in_s;
            state_d = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (acc_s && pop_s) begin
            main_d  = in_s;
            state_d = ST_ONE;
          end else if (acc_s) begin
            skid_d  = in_s;
            state_d = ST_FULL;
          end else if (pop_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          // ready_e is low here, so only the head can move.
          if (pop_s) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Saturating backpressure counter; flushed cycles are not counted.
  always_comb begin
    stall_d = stall_q;
    if (ex_i.valid && !ready_e_s && !flush_i && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  // State, entry and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  assign ex_i.ready       = ready_e_s;
  assign mem_o.valid      = valid_m_s;
  // Write enables are gated by valid so bubbles never write.
  assign mem_o.reg_write  = main_q.reg_write & valid_m_s;
  assign mem_o.mem_write  = main_q.mem_write & valid_m_s;
  assign mem_o.result_src = main_q.result_src;
  assign mem_o.funct3     = main_q.funct3;
  assign mem_o.alu_result = main_q.alu_result;
  assign mem_o.write_data = main_q.write_data;
  assign mem_o.rd         = main_q.rd;
  assign mem_o.pc_plus4   = main_q.pc_plus4;
  assign stall_cnt_o      = stall_q;

endmodule
